// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential instruction-memory requests,
// tracks them in a small in-order queue and presents fetched words to decode.
// Redirects flush the queue and discard responses that are still in flight.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    // Pointer width, entry-count width (holds 0..DEPTH) and drop-counter width.
    // The drop counter is two bits wider than a full queue so that several
    // back-to-back redirects can be absorbed while old responses are pending.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = CW + 2;

    localparam logic [CW-1:0]   DEPTH_C     = CW'(DEPTH);
    localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;   // oldest entry (next to pop)
    logic [PW-1:0]   fill_q, fill_d;   // oldest allocated but unfilled entry
    logic [PW-1:0]   tail_q, tail_d;   // next entry to allocate
    logic [CW-1:0]   cnt_q, cnt_d;     // allocated entries (outstanding + filled)
    logic [CW-1:0]   out_q, out_d;     // outstanding (allocated, unfilled)
    logic [DW-1:0]   drop_q, drop_d;   // stale responses still to discard

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic run;
    logic redirect_run;
    logic accept;
    logic head_valid;
    logic resp_live;
    logic drop_en;
    logic fill_en;
    logic pop;
    logic unused_bits;

    // The two low bits of a redirect target are always forced to zero.
    assign unused_bits = ^redirect_pc_i[1:0];

    assign run          = (state_q == S_RUN);
    assign redirect_run = run & redirect_i;
    // Entries fill strictly in order from the head, so the head is ready
    // exactly when at least one allocated entry is no longer outstanding.
    assign head_valid   = (cnt_q != out_q);
    assign imem_req_o   = run & ~redirect_i & (cnt_q < DEPTH_C);
    assign imem_addr_o  = fetch_pc_q;
    assign accept       = imem_req_o & imem_ready_i;
    // A response counts only if some request (live or stale) is in flight.
    assign resp_live    = imem_rvalid_i & ((drop_q != '0) | (out_q != '0));
    assign drop_en      = imem_rvalid_i & (drop_q != '0);
    assign fill_en      = imem_rvalid_i & (drop_q == '0) & (out_q != '0) & ~redirect_run;
    assign pop          = head_valid & instr_ready_i & ~redirect_run;

    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? data_mem[head_q] : '0;
    assign instr_pc_o    = head_valid ? pc_mem[head_q]   : '0;

    // Next-state logic for the FSM, fetch PC, queue pointers and counters.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        drop_d     = drop_q;

        if (state_q == S_IDLE && start_i) begin
            state_d = S_RUN;
        end

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (redirect_run) begin
            // Flush everything; every request still unanswered after this
            // cycle becomes a response to throw away.
            head_d = '0;
            fill_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            out_d  = '0;
            drop_d = drop_q + DW'(out_q) - DW'(resp_live);
        end else begin
            if (accept) begin
                tail_d = tail_q + PW'(1);
            end
            if (fill_en) begin
                fill_d = fill_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (drop_en) begin
                drop_d = drop_q - DW'(1);
            end
            cnt_d = cnt_q + CW'(accept) - CW'(pop);
            out_d = out_q + CW'(accept) - CW'(fill_en);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC_AL;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage: PC tagged on allocation, instruction word on fill.
    // Contents need no reset because outputs are gated by head_valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pc_mem[tail_q] <= fetch_pc_q;
        end
        if (fill_en) begin
            data_mem[fill_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with an in-order memory model
// and a queue-based reference model checked on every cycle.
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, imem_ready, imem_rvalid, redirect, instr_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;

    logic        rst_w, start_w, req_w, valid_w;
    logic [31:0] addr_w, instr_w, pc_w;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst_w), .start_i(start_w),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ready_i(1'b1),
        .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .instr_valid_o(valid_w), .instr_o(instr_w), .instr_pc_o(pc_w),
        .instr_ready_i(1'b1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    // Reference model state
    ent_t        mq[$];
    bit          m_run;
    logic [31:0] m_pc;
    int          m_drop;

    // Memory model and logs
    mreq_t       memq[$];
    int          lat = 1;
    int          cyc = 0;
    int          last_due = -1;
    bit          mem_hold = 0;
    bit          spur = 0;
    logic [31:0] req_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_data_log[$];

    function automatic logic [31:0] dfn(input logic [31:0] a);
        return (a << 8) ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run  = 0;
        m_pc   = 32'h0;
        m_drop = 0;
    endtask

    function automatic int filled_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].filled) n++;
        return n;
    endfunction

    // One clock cycle: drive memory response, compare at negedge, advance model.
    task automatic cycle();
        bit          e_req, e_valid, do_pop;
        logic [31:0] e_instr, e_pc;
        int          d, inflight;
        ent_t        e;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!mem_hold && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = dfn(memq[0].addr);
            void'(memq.pop_front());
        end else if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        e_req   = m_run && !redirect && (mq.size() < DEPTH);
        e_valid = (mq.size() > 0) && mq[0].filled;
        e_instr = e_valid ? mq[0].data : 32'h0;
        e_pc    = e_valid ? mq[0].pc   : 32'h0;
        chk("imem_req",    imem_req,    e_req);
        chk("imem_addr",   imem_addr,   m_pc);
        chk("instr_valid", instr_valid, e_valid);
        chk("instr",       instr,       e_instr);
        chk("instr_pc",    instr_pc,    e_pc);
        if (imem_req && imem_ready) begin
            req_log.push_back(imem_addr);
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            memq.push_back('{addr: imem_addr, due: d});
        end
        if (instr_valid && instr_ready && !(m_run && redirect)) begin
            pop_pc_log.push_back(instr_pc);
            pop_data_log.push_back(instr);
            $display("pop  pc=%h instr=%h cyc=%0d", instr_pc, instr, cyc);
        end
        // Reference model update for this clock edge
        if (!m_run) begin
            if (start)    m_run = 1;
            if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
        end else if (redirect) begin
            inflight = m_drop;
            foreach (mq[i]) if (!mq[i].filled) inflight++;
            m_drop = inflight - ((imem_rvalid && inflight > 0) ? 1 : 0);
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            do_pop = e_valid && instr_ready;
            if (imem_rvalid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            e = mq[i];
                            e.filled = 1;
                            e.data = imem_rdata;
                            mq[i] = e;
                            break;
                        end
                    end
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (e_req && imem_ready) begin
                mq.push_back('{pc: m_pc, data: 32'h0, filled: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset: check outputs at once, hold, release, drain stale responses.
    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("rst_req",   imem_req,    1'b0);
        chk("rst_addr",  imem_addr,   32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr,       32'h0);
        chk("rst_pc",    instr_pc,    32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        for (int i = 0; i < 20 && memq.size() > 0; i++) cycle();
        chk("drain_stale", memq.size(), 0);
        req_log.delete();
        pop_pc_log.delete();
        pop_data_log.delete();
    endtask

    initial begin
        logic [31:0] wexp [3];
        int          n0, p0;
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;

        rst_n = 0; start = 0; imem_ready = 1; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 1;
        rst_w = 0; start_w = 0;

        // Sequential fetch, single-cycle memory, decode always ready
        do_reset();
        repeat (2) cycle();
        start = 1; cycle(); start = 0;
        repeat (14) cycle();
        chk("s1_req0", req_log[0], 32'h0);
        chk("s1_req1", req_log[1], 32'h4);
        chk("s1_req2", req_log[2], 32'h8);
        chk("s1_req3", req_log[3], 32'hC);
        chk("s1_nreq", req_log.size(), 14);
        chk("s1_pop0_pc",   pop_pc_log[0],   32'h0);
        chk("s1_pop0_data", pop_data_log[0], 32'hC0DE_0013);
        chk("s1_pop1_pc",   pop_pc_log[1],   32'h4);
        chk("s1_pop1_data", pop_data_log[1], 32'hC0DE_0413);
        chk("s1_npop", pop_pc_log.size(), 12);

        // Decode stalled: queue fills to DEPTH, then drains in order
        do_reset();
        instr_ready = 0;
        start = 1; cycle(); start = 0;
        repeat (10) cycle();
        chk("s2_nreq_full", req_log.size(), 4);
        chk("s2_hold_valid", instr_valid, 1'b1);
        chk("s2_hold_pc", instr_pc, 32'h0);
        instr_ready = 1;
        repeat (8) cycle();
        chk("s2_pop0", pop_pc_log[0], 32'h0);
        chk("s2_pop1", pop_pc_log[1], 32'h4);
        chk("s2_pop2", pop_pc_log[2], 32'h8);
        chk("s2_pop3", pop_pc_log[3], 32'hC);
        chk("s2_resume", req_log[4], 32'h10);

        // Redirect with 0x8 and 0xC outstanding
        do_reset();
        lat = 1;
        start = 1; cycle(); start = 0;
        repeat (3) cycle();
        mem_hold = 1;
        cycle();
        redirect = 1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 0; mem_hold = 0;
        repeat (8) cycle();
        chk("s3_nreq_before", req_log[3], 32'hC);
        chk("s3_req_after", req_log[4], 32'h100);
        chk("s3_pop_after_pc", pop_pc_log[2], 32'h100);
        chk("s3_pop_after_data", pop_data_log[2], 32'hC0DF_0013);

        // Back-to-back redirects while stale responses are still returning
        lat = 2;
        repeat (3) cycle();
        redirect = 1; redirect_pc = 32'h0000_2000; cycle(); redirect = 0;
        cycle();
        redirect = 1; redirect_pc = 32'h0000_3002; cycle(); redirect = 0;
        repeat (12) cycle();

        // Memory not ready for three cycles, then mixed back-pressure
        imem_ready = 0;
        repeat (3) cycle();
        imem_ready = 1;
        for (int i = 0; i < 30; i++) begin
            imem_ready  = (i % 3 != 2);
            instr_ready = (i % 4 != 0);
            lat         = 1 + (i % 3);
            cycle();
        end
        imem_ready = 1; instr_ready = 1; lat = 1;
        repeat (10) cycle();

        // Reset with three filled entries, then restart at RESET_PC
        do_reset();
        instr_ready = 0;
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 20 && filled_cnt() < 3; i++) cycle();
        chk("s5_three_filled", filled_cnt(), 3);
        chk("s5_valid_before", instr_valid, 1'b1);
        do_reset();
        instr_ready = 1;
        start = 1; cycle(); start = 0;
        repeat (4) cycle();
        chk("s5_first_req", req_log[0], 32'h0);

        // Redirect and a spurious response while idle
        do_reset();
        redirect = 1; redirect_pc = 32'h0000_0203; spur = 1;
        cycle();
        redirect = 0; spur = 0;
        cycle();
        chk("s6_idle_req", imem_req, 1'b0);
        start = 1; cycle(); start = 0;
        repeat (5) cycle();
        chk("s6_req0", req_log[0], 32'h200);
        chk("s6_req1", req_log[1], 32'h204);
        chk("s6_pop0", pop_pc_log[0], 32'h200);

        // RESET_PC near the top of the address space wraps to zero
        rst_w = 1; start_w = 1;
        @(negedge clk);
        chk("wrap_idle_req", req_w, 1'b0);
        @(posedge clk); #1;
        start_w = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wrap_req", req_w, 1'b1);
            chk("wrap_addr", addr_w, wexp[k]);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
